// File: rtl/uart_csr_bank.sv
// UART control/status register bank: bus-facing CSR slave that holds line config, baud divisor,
// interrupt enable/status and single-entry TX/RX holding registers for the UART core.
module uart_csr_bank #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 8,
   parameter int CHAR_W  = 9,
   parameter int DIV_W   = 16,
   parameter int DIV_RST = 27
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cs,
   input  logic              wen,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic [4:0]        word_length,
   output logic              num_stop_bits,
   output logic              oversample_by_3,
   output logic              enable_uart,
   output logic [DIV_W-1:0]  baud_div,
   output logic [CHAR_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [CHAR_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              irq
);

   localparam logic [ADDR_W-3:0] REG_CTRL   = (ADDR_W-2)'(0);
   localparam logic [ADDR_W-3:0] REG_STATUS = (ADDR_W-2)'(1);
   localparam logic [ADDR_W-3:0] REG_DATA   = (ADDR_W-2)'(2);
   localparam logic [ADDR_W-3:0] REG_BAUD   = (ADDR_W-2)'(3);
   localparam logic [ADDR_W-3:0] REG_INT_EN = (ADDR_W-2)'(4);
   localparam logic [ADDR_W-3:0] REG_INT_ST = (ADDR_W-2)'(5);

   logic [7:0]        ctrl;
   logic [3:0]        int_en;
   logic [3:0]        int_stat;
   logic [CHAR_W-1:0] rx_char;
   logic              rx_full;
   logic [DATA_W-1:0] read_mux;

   logic [ADDR_W-3:0] word;
   logic              wr_acc, rd_acc;
   logic              tx_hs, tx_push, tx_accept, tx_drop, tx_done;
   logic              rx_pop, rx_load, rx_over;
   logic [3:0]        int_events, int_clear;
   logic              unused_bits;

   assign word        = addr[ADDR_W-1:2];
   assign wr_acc      = cs & wen;
   assign rd_acc      = cs & ~wen;
   assign unused_bits = ^{addr[1:0], wdata};

   // A push is accepted when the holding reg is empty or drains in the same cycle.
   assign tx_hs     = tx_valid & tx_ready;
   assign tx_push   = wr_acc & (word == REG_DATA);
   assign tx_accept = tx_push & (~tx_valid | tx_hs);
   assign tx_drop   = tx_push & tx_valid & ~tx_hs;
   assign tx_done   = tx_hs & ~tx_push;

   // A pop frees the RX slot in time for a char arriving in the same cycle.
   assign rx_pop  = rd_acc & (word == REG_DATA) & rx_full;
   assign rx_load = rx_valid & (~rx_full | rx_pop);
   assign rx_over = rx_valid & rx_full & ~rx_pop;

   assign int_events = {tx_drop, rx_over, tx_done, rx_load};
   assign int_clear  = (wr_acc && word == REG_INT_ST) ? wdata[3:0] : 4'b0;

   assign word_length     = ctrl[4:0];
   assign num_stop_bits   = ctrl[5];
   assign oversample_by_3 = ctrl[6];
   assign enable_uart     = ctrl[7];

   always_comb begin
      read_mux = '0;
      case (word)
         REG_CTRL:   read_mux = DATA_W'(ctrl);
         REG_STATUS: read_mux = DATA_W'({irq, rx_full, tx_valid, int_stat[2], ~tx_valid});
         REG_DATA:   read_mux = rx_full ? DATA_W'(rx_char) : '0;
         REG_BAUD:   read_mux = DATA_W'(baud_div);
         REG_INT_EN: read_mux = DATA_W'(int_en);
         REG_INT_ST: read_mux = DATA_W'(int_stat);
         default:    read_mux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl     <= '0;
         baud_div <= DIV_W'(DIV_RST);
         int_en   <= '0;
         int_stat <= '0;
         tx_data  <= '0;
         tx_valid <= 1'b0;
         rx_char  <= '0;
         rx_full  <= 1'b0;
         rdata    <= '0;
         rvalid   <= 1'b0;
         irq      <= 1'b0;
      end else begin
         if (wr_acc && word == REG_CTRL)   ctrl     <= wdata[7:0];
         if (wr_acc && word == REG_BAUD)   baud_div <= wdata[DIV_W-1:0];
         if (wr_acc && word == REG_INT_EN) int_en   <= wdata[3:0];
         // Set events are OR-ed in after the clear so they win a same-cycle W1C.
         int_stat <= (int_stat & ~int_clear) | int_events;
         irq      <= |(int_stat & int_en);

         if (tx_accept) begin
            tx_data  <= wdata[CHAR_W-1:0];
            tx_valid <= 1'b1;
         end else if (tx_hs) begin
            tx_valid <= 1'b0;
         end

         if (rx_load) begin
            rx_char <= rx_data;
            rx_full <= 1'b1;
         end else if (rx_pop) begin
            rx_full <= 1'b0;
         end

         rvalid <= rd_acc;
         rdata  <= rd_acc ? read_mux : '0;
      end
   end

endmodule

// File: tb/tb_uart_csr_bank.sv
// Self-checking bench for uart_csr_bank: queue-based reference model, scoreboard for reads,
// directed scenarios followed by randomized bus/TX/RX traffic.
module tb_uart_csr_bank;

   logic        clk;
   logic        reset;
   logic        cs;
   logic        wen;
   logic [7:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rvalid;
   logic [4:0]  word_length;
   logic        num_stop_bits;
   logic        oversample_by_3;
   logic        enable_uart;
   logic [15:0] baud_div;
   logic [8:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [8:0]  rx_data;
   logic        rx_valid;
   logic        irq;

   int tests_run = 0;
   int tests_failed = 0;

   uart_csr_bank dut (
      .clk(clk), .reset(reset), .cs(cs), .wen(wen), .addr(addr), .wdata(wdata),
      .rdata(rdata), .rvalid(rvalid), .word_length(word_length),
      .num_stop_bits(num_stop_bits), .oversample_by_3(oversample_by_3),
      .enable_uart(enable_uart), .baud_div(baud_div), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: holding registers are depth-1 queues, reads produce scoreboard entries.
   logic [7:0]  m_ctrl = 8'h00;
   logic [15:0] m_baud = 16'd27;
   logic [3:0]  m_en = 4'h0;
   logic [3:0]  m_stat = 4'h0;
   logic        m_irq = 1'b0;
   logic        m_rvalid = 1'b0;
   logic [8:0]  tx_q[$];
   logic [8:0]  rx_q[$];
   logic [31:0] exp_q[$];

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   always @(posedge clk or posedge reset) begin : ref_model
      int          idx;
      logic [31:0] rval;
      logic [3:0]  ev;
      logic [3:0]  clr;
      logic        hs, rd_acc, wr_acc, next_irq;
      if (reset) begin
         m_ctrl = 8'h00; m_baud = 16'd27; m_en = 4'h0; m_stat = 4'h0;
         m_irq = 1'b0; m_rvalid = 1'b0;
         tx_q.delete(); rx_q.delete(); exp_q.delete();
      end else begin
         idx    = int'(addr[7:2]);
         rd_acc = cs && !wen;
         wr_acc = cs && wen;
         ev     = 4'h0;
         rval   = 32'h0;
         if (rd_acc) begin
            case (idx)
               0: rval = {24'h0, m_ctrl};
               1: rval = {27'h0, m_irq, rx_q.size() != 0, tx_q.size() != 0, m_stat[2],
                          tx_q.size() == 0};
               2: rval = (rx_q.size() != 0) ? {23'h0, rx_q[0]} : 32'h0;
               3: rval = {16'h0, m_baud};
               4: rval = {28'h0, m_en};
               5: rval = {28'h0, m_stat};
               default: rval = 32'h0;
            endcase
            exp_q.push_back(rval);
         end
         m_rvalid = rd_acc;
         next_irq = |(m_stat & m_en);

         hs = (tx_q.size() != 0) && tx_ready;
         if (hs) void'(tx_q.pop_front());
         if (wr_acc && idx == 2) begin
            if (tx_q.size() == 0) tx_q.push_back(wdata[8:0]);
            else ev[3] = 1'b1;
         end else if (hs) begin
            ev[1] = 1'b1;
         end

         if (rd_acc && idx == 2 && rx_q.size() != 0) void'(rx_q.pop_front());
         if (rx_valid) begin
            if (rx_q.size() == 0) begin
               rx_q.push_back(rx_data);
               ev[0] = 1'b1;
            end else begin
               ev[2] = 1'b1;
            end
         end

         clr = (wr_acc && idx == 5) ? wdata[3:0] : 4'h0;
         m_stat = (m_stat & ~clr) | ev;
         if (wr_acc && idx == 0) m_ctrl = wdata[7:0];
         if (wr_acc && idx == 3) m_baud = wdata[15:0];
         if (wr_acc && idx == 4) m_en = wdata[3:0];
         m_irq = next_irq;
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents read data, and tracks the outputs.
   always @(negedge clk) begin
      check_output("rvalid", {31'h0, rvalid}, {31'h0, m_rvalid});
      if (rvalid && exp_q.size() != 0) check_output("rdata", rdata, exp_q.pop_front());
      else if (!rvalid) check_output("rdata_idle", rdata, 32'h0);
      check_output("tx_valid", {31'h0, tx_valid}, {31'h0, tx_q.size() != 0});
      if (tx_valid && tx_q.size() != 0) check_output("tx_data", {23'h0, tx_data}, {23'h0, tx_q[0]});
      check_output("irq", {31'h0, irq}, {31'h0, m_irq});
      check_output("baud_div", {16'h0, baud_div}, {16'h0, m_baud});
      check_output("ctrl_out", {24'h0, enable_uart, oversample_by_3, num_stop_bits, word_length},
                   {24'h0, m_ctrl});
   end

   task automatic apply_stimulus(input logic c, input logic w, input logic [7:0] a,
                                 input logic [31:0] d, input logic rv, input logic [8:0] rc);
      cs = c; wen = w; addr = a; wdata = d; rx_valid = rv; rx_data = rc;
      @(negedge clk);
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
      apply_stimulus(1'b1, 1'b1, a, d, 1'b0, 9'h0);
   endtask

   task automatic bus_read(input logic [7:0] a);
      apply_stimulus(1'b1, 1'b0, a, 32'h0, 1'b0, 9'h0);
   endtask

   task automatic idle();
      apply_stimulus(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 9'h0);
   endtask

   task automatic rx_char(input logic [8:0] c);
      apply_stimulus(1'b0, 1'b0, 8'h0, 32'h0, 1'b1, c);
   endtask

   initial begin
      reset = 1'b1; cs = 1'b0; wen = 1'b0; addr = '0; wdata = '0;
      tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      check_output("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      check_output("rst_irq", {31'h0, irq}, 32'h0);
      check_output("rst_baud", {16'h0, baud_div}, 32'd27);
      bus_read(8'h0C);
      check_output("rd_baud_rvalid", {31'h0, rvalid}, 32'h1);
      check_output("rd_baud", rdata, 32'd27);
      bus_read(8'h00);
      check_output("rd_ctrl_rst", rdata, 32'h0);
      bus_read(8'h10);
      bus_read(8'h14);
      idle();
      check_output("rvalid_one_cycle", {31'h0, rvalid}, 32'h0);

      bus_write(8'h00, 32'hA8);
      check_output("word_length", {27'h0, word_length}, 32'd8);
      check_output("stop_bits", {31'h0, num_stop_bits}, 32'h1);
      check_output("oversample", {31'h0, oversample_by_3}, 32'h0);
      check_output("enable", {31'h0, enable_uart}, 32'h1);

      bus_write(8'h08, 32'h55);
      repeat (3) idle();
      check_output("tx_hold_valid", {31'h0, tx_valid}, 32'h1);
      check_output("tx_hold_data", {23'h0, tx_data}, 32'h55);
      tx_ready = 1'b1;
      idle();
      tx_ready = 1'b0;
      check_output("tx_drained", {31'h0, tx_valid}, 32'h0);
      bus_read(8'h14);
      check_output("tx_done_stat", rdata, 32'h2);
      bus_write(8'h14, 32'hF);

      bus_write(8'h08, 32'h11);
      bus_write(8'h08, 32'h22);
      check_output("tx_drop_data", {23'h0, tx_data}, 32'h11);
      bus_read(8'h14);
      check_output("tx_drop_stat", rdata, 32'h8);
      bus_write(8'h14, 32'h8);
      bus_read(8'h14);
      check_output("w1c_clear", rdata, 32'h0);
      tx_ready = 1'b1;
      idle();
      tx_ready = 1'b0;
      bus_write(8'h14, 32'hF);

      bus_write(8'h10, 32'h1);
      rx_char(9'h1A3);
      check_output("irq_not_yet", {31'h0, irq}, 32'h0);
      idle();
      check_output("irq_set", {31'h0, irq}, 32'h1);
      rx_char(9'h0F0);
      bus_read(8'h14);
      check_output("overrun_stat", rdata, 32'h5);
      bus_read(8'h08);
      check_output("rx_pop", rdata, 32'h1A3);
      bus_read(8'h04);
      check_output("status_after_pop", rdata, 32'h13);

      bus_write(8'h14, 32'hF);
      rx_char(9'h033);
      bus_write(8'h14, 32'hF);
      apply_stimulus(1'b1, 1'b0, 8'h08, 32'h0, 1'b1, 9'h044);
      check_output("pop_load_old", rdata, 32'h033);
      bus_read(8'h04);
      check_output("pop_load_full", {31'h0, rdata[3]}, 32'h1);
      check_output("pop_load_no_ovr", {31'h0, rdata[1]}, 32'h0);
      bus_read(8'h08);
      check_output("pop_load_new", rdata, 32'h044);
      bus_read(8'h18);
      check_output("unmapped_rd", rdata, 32'h0);

      for (int i = 0; i < 2000; i++) begin
         tx_ready = ($urandom_range(0, 1) == 1);
         apply_stimulus($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                        8'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3)),
                        $urandom, $urandom_range(0, 3) == 0, 9'($urandom));
      end

      tx_ready = 1'b0;
      bus_write(8'h08, 32'h1FF);
      rx_char(9'h0AA);
      cs = 1'b1; wen = 1'b0; addr = 8'h08; rx_valid = 1'b0;
      @(posedge clk);
      #2;
      check_output("mid_rvalid", {31'h0, rvalid}, 32'h1);
      reset = 1'b1;
      #1;
      check_output("mid_rst_rvalid", {31'h0, rvalid}, 32'h0);
      check_output("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
      check_output("mid_rst_rdata", rdata, 32'h0);
      cs = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      bus_read(8'h08);
      check_output("post_rst_rx_empty", rdata, 32'h0);
      bus_read(8'h0C);
      check_output("post_rst_baud", rdata, 32'd27);
      idle();
      check_output("scoreboard_drained", exp_q.size(), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
